fetch_unit: RTL

Instruction-fetch front end of the 5-stage pipelined RISC-V core. It sits directly upstream of the IF/ID pipeline register and owns the fetch PC. It issues in-order requests to instruction memory through a valid/ready request and response handshake, and buffers returned instructions in a small queue. It presents one (pc, instruction) pair per cycle to IF/ID, honours a stall from the hazard unit, and accepts branch redirects from EX, squashing wrong-path fetches.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests under a
// shared credit limit, buffers responses and presents one (pc, instr) per cycle to IF/ID.
`timescale 1ns/1ps

module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            flush_ifid
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  logic            run;
  logic [XLEN-1:0] fetch_pc;
  logic            epoch;

  logic [XLEN-1:0] ob_pc [FQ_DEPTH];
  logic            ob_ep [FQ_DEPTH];
  logic [PW-1:0]   ob_rd, ob_wr;
  logic [CW-1:0]   out_cnt;

  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [ILEN-1:0] q_instr [FQ_DEPTH];
  logic [PW-1:0]   q_rd, q_wr;
  logic [CW-1:0]   q_cnt;

  logic            q_valid, pop, accept, rsp_fire, keep;
  logic [CW:0]     occ;
  logic [XLEN-1:0] redirect_aligned;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_valid          = (q_cnt != '0);
  assign pop              = q_valid & ~stall;
  assign occ              = (CW+1)'(out_cnt) + (CW+1)'(q_cnt) - (CW+1)'(pop);
  // run holds off the first request until one full cycle after reset release.
  assign imem_req_valid   = run & (occ < (CW+1)'(FQ_DEPTH)) & ~redirect_valid;
  assign imem_req_addr    = fetch_pc;
  assign accept           = imem_req_valid & imem_req_ready;
  assign rsp_fire         = imem_rsp_valid & (out_cnt != '0);
  assign keep             = rsp_fire & (ob_ep[ob_rd] == epoch) & ~redirect_valid;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  assign if_valid   = q_valid;
  assign if_instr   = q_valid ? q_instr[q_rd] : NOP;
  assign if_pc      = q_valid ? q_pc[q_rd]    : '0;
  assign flush_ifid = redirect_valid & rst;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
      ob_rd    <= '0;
      ob_wr    <= '0;
      out_cnt  <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      q_cnt    <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        epoch    <= ~epoch;
      end else if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end

      if (accept)   ob_wr <= ptr_inc(ob_wr);
      if (rsp_fire) ob_rd <= ptr_inc(ob_rd);
      out_cnt <= out_cnt + CW'(accept) - CW'(rsp_fire);

      if (redirect_valid) begin
        q_rd  <= '0;
        q_wr  <= '0;
        q_cnt <= '0;
      end else begin
        if (keep) q_wr <= ptr_inc(q_wr);
        if (pop)  q_rd <= ptr_inc(q_rd);
        q_cnt <= q_cnt + CW'(keep) - CW'(pop);
      end
    end
  end

  // NOTE: storage arrays carry no reset; the counters alone say which entries are meaningful.
  always_ff @(posedge clk) begin
    // Retag every in-flight request with the old epoch so a second redirect cannot revive it.
    if (redirect_valid) begin
      for (int i = 0; i < FQ_DEPTH; i++) ob_ep[i] <= epoch;
    end
    if (accept) begin
      ob_pc[ob_wr] <= fetch_pc;
      ob_ep[ob_wr] <= epoch;
    end
    if (keep) begin
      q_pc[q_wr]    <= ob_pc[ob_rd];
      q_instr[q_wr] <= imem_rsp_data;
    end
  end

  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && out_cnt == '0));

endmodule
